// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared LSU types: control opcodes, FSM states, byte-enable patterns and
// small opcode classification helpers.
package lsu_mem_ctrl_pkg;

  typedef enum logic [3:0] {
    LSU_NOP, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsuCtrl_e;

  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsuState_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_store(lsuCtrl_e c);
    return c inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  function automatic logic is_misaligned(lsuCtrl_e c, logic [1:0] off);
    logic m;
    m = 1'b0;
    case (c)
      LSU_LH, LSU_LHU, LSU_SH: m = off[0];
      LSU_LW, LSU_SW:          m = (off != 2'b00);
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Picks the addressed byte/half out of the raw memory word and sign- or
// zero-extends it according to the load opcode.
module lsu_mem_ctrl_load_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsuCtrl_e          ctrl,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   raw,
  output logic [XLEN-1:0]   ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = raw[{off, 3'b000} +: 8];
  assign half_v = raw[{off[1], 4'b0000} +: 16];

  always_comb begin
    ext = raw;
    case (ctrl)
      LSU_LB:  ext = {{(XLEN-8){byte_v[7]}}, byte_v};
      LSU_LBU: ext = {{(XLEN-8){1'b0}}, byte_v};
      LSU_LH:  ext = {{(XLEN-16){half_v[15]}}, half_v};
      LSU_LHU: ext = {{(XLEN-16){1'b0}}, half_v};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: req/gnt/rvalid handshake to data memory, stalls the
// pipeline while an access is outstanding, returns extended load data.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  input  lsuCtrl_e        lsu_ctrl,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_misaligned,
  output logic            lsu_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int CW = 16;

  lsuState_e       state_q, state_d;
  lsuCtrl_e        ctrl_q, ctrl_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            start;
  logic [XLEN-1:0] load_ext;
  logic [3:0]      be;

  assign start = lsu_valid && (lsu_ctrl != LSU_NOP);

  lsu_mem_ctrl_load_align #(.XLEN(XLEN)) u_align (
    .ctrl (ctrl_q),
    .off  (addr_q[1:0]),
    .raw  (dmem_rdata),
    .ext  (load_ext)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_IDLE: if (start) begin
        ctrl_d  = lsu_ctrl;
        addr_d  = lsu_addr;
        wdata_d = lsu_wdata;
        err_d   = 1'b0;
        cnt_d   = '0;
        mis_d   = is_misaligned(lsu_ctrl, lsu_addr[1:0]);
        state_d = mis_d ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: if (dmem_gnt) begin
        cnt_d   = '0;
        state_d = is_store(ctrl_q) ? LSU_DONE : LSU_WAIT;
      end
      LSU_WAIT: begin
        // rvalid wins over a timeout landing in the same cycle
        if (dmem_rvalid) begin
          rdata_d = load_ext;
          state_d = LSU_DONE;
        end else if ((MAX_WAIT != 0) && (cnt_q == CW'(MAX_WAIT - 1))) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        mis_d   = 1'b0;
        err_d   = 1'b0;
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      ctrl_q  <= LSU_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (ctrl_q)
      LSU_LB, LSU_LBU, LSU_SB: be = BE_BYTE << addr_q[1:0];
      LSU_LH, LSU_LHU, LSU_SH: be = BE_HALF << {addr_q[1], 1'b0};
      LSU_LW, LSU_SW:          be = BE_WORD;
      default:                 be = 4'b0000;
    endcase
  end

  always_comb begin
    dmem_wdata = wdata_q;
    case (ctrl_q)
      LSU_SB:  dmem_wdata = {(XLEN/8){wdata_q[7:0]}};
      LSU_SH:  dmem_wdata = {(XLEN/16){wdata_q[15:0]}};
      default: dmem_wdata = wdata_q;
    endcase
  end

  assign dmem_req       = (state_q == LSU_REQ);
  assign dmem_we        = dmem_req && is_store(ctrl_q);
  assign dmem_be        = dmem_req ? be : 4'b0000;
  assign dmem_addr      = {addr_q[XLEN-1:2], 2'b00};
  assign lsu_done       = (state_q == LSU_DONE);
  assign lsu_misaligned = lsu_done && mis_q;
  assign lsu_err        = lsu_done && err_q;
  assign lsu_rdata      = rdata_q;
  // reset also masks the combinational accept term so stall is 0 under reset
  assign lsu_stall      = !rst && (((state_q == LSU_IDLE) && start) ||
                                   (state_q == LSU_REQ) || (state_q == LSU_WAIT));

endmodule
